// File: rtl/pair_compare_pkg.sv
// rtl/pair_compare_pkg.sv - shared state encoding, slice width and derived-width helpers
package pair_compare_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam int SLICE_W = 2;

   // Slice index never narrower than one bit, even for a single-slice compare.
   function automatic int idx_w(input int width);
      int nslice;
      nslice = width / SLICE_W;
      return (nslice <= 1) ? 1 : $clog2(nslice);
   endfunction

   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/pair_compare_if.sv
// rtl/pair_compare_if.sv - request/result bundle between requester and compare sequencer
interface pair_compare_if
   import pair_compare_pkg::*;
#(
   parameter int WIDTH = 8
);
   localparam int IDXW = idx_w(WIDTH);
   localparam int CNTW = cnt_w(WIDTH);

   logic             start;
   logic             abort;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             eq;
   logic             any_match;
   logic [IDXW-1:0]  mismatch_idx;
   logic [CNTW-1:0]  mismatch_cnt;

   modport master (
      output start, abort, a_in, b_in,
      input  busy, done, eq, any_match, mismatch_idx, mismatch_cnt
   );

   modport slave (
      input  start, abort, a_in, b_in,
      output busy, done, eq, any_match, mismatch_idx, mismatch_cnt
   );

endinterface

// File: rtl/pair_match_cell.sv
// rtl/pair_match_cell.sv - 2-bit slice: per-bit equality and "any position equal"
module pair_match_cell (
   input  logic x1,
   input  logic x2,
   input  logic y1,
   input  logic y2,
   output logic e1,
   output logic e2,
   output logic a
);

   assign e1 = ~(x1 ^ y1);
   assign e2 = ~(x2 ^ y2);
   assign a  = e1 | e2;

endmodule

// File: rtl/pair_compare_seq.sv
// rtl/pair_compare_seq.sv - walks operands two bits per clock through one shared match cell
module pair_compare_seq
   import pair_compare_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   pair_compare_if.slave bus
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IDXW   = idx_w(WIDTH);
   localparam int CNTW   = cnt_w(WIDTH);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IDXW-1:0]  idx;
   logic             eq_acc, any_acc, found;
   logic [CNTW-1:0]  cnt;
   logic [IDXW-1:0]  midx;

   logic             busy_q, done_q, eq_q, any_q;
   logic [IDXW-1:0]  midx_q;
   logic [CNTW-1:0]  cnt_q;

   logic [1:0]       a_sl, b_sl;
   logic             e1, e2, cell_a;
   logic [1:0]       diff;
   logic             slice_diff, last;
   logic             eq_nxt, any_nxt, found_nxt;
   logic [CNTW-1:0]  cnt_nxt;
   logic [IDXW-1:0]  midx_nxt;

   assign a_sl = a_q[{idx, 1'b0} +: 2];
   assign b_sl = b_q[{idx, 1'b0} +: 2];

   pair_match_cell u_cell (
      .x1 (a_sl[0]),
      .x2 (a_sl[1]),
      .y1 (b_sl[0]),
      .y2 (b_sl[1]),
      .e1 (e1),
      .e2 (e2),
      .a  (cell_a)
   );

   assign diff       = {1'b0, ~e1} + {1'b0, ~e2};
   assign slice_diff = ~(e1 & e2);
   assign last       = (idx == IDXW'(NSLICE - 1));
   assign eq_nxt     = eq_acc & e1 & e2;
   assign any_nxt    = any_acc | cell_a;
   assign cnt_nxt    = cnt + CNTW'(diff);
   assign found_nxt  = found | slice_diff;
   assign midx_nxt   = (!found && slice_diff) ? idx : midx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx     <= '0;
         eq_acc  <= 1'b0;
         any_acc <= 1'b0;
         found   <= 1'b0;
         cnt     <= '0;
         midx    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         eq_q    <= 1'b0;
         any_q   <= 1'b0;
         midx_q  <= '0;
         cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  a_q     <= bus.a_in;
                  b_q     <= bus.b_in;
                  idx     <= '0;
                  eq_acc  <= 1'b1;
                  any_acc <= 1'b0;
                  found   <= 1'b0;
                  cnt     <= '0;
                  midx    <= '0;
                  busy_q  <= 1'b1;
                  eq_q    <= 1'b0;
                  any_q   <= 1'b0;
                  midx_q  <= '0;
                  cnt_q   <= '0;
                  state   <= S_RUN;
               end
            end
            S_RUN: begin
               if (bus.abort) begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end else begin
                  eq_acc  <= eq_nxt;
                  any_acc <= any_nxt;
                  cnt     <= cnt_nxt;
                  found   <= found_nxt;
                  midx    <= midx_nxt;
                  idx     <= idx + IDXW'(1);
                  // Results publish with the last slice folded in, so they are visible alongside done.
                  if (last) begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                     eq_q   <= eq_nxt;
                     any_q  <= any_nxt;
                     midx_q <= midx_nxt;
                     cnt_q  <= cnt_nxt;
                  end
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= S_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.eq           = eq_q;
   assign bus.any_match    = any_q;
   assign bus.mismatch_idx = midx_q;
   assign bus.mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_pair_compare_seq.sv
// tb/tb_pair_compare_seq.sv - directed self-checking bench for pair_compare_seq at WIDTH=8
module tb_pair_compare_seq;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   pair_compare_if #(.WIDTH(8)) bus_i ();

   pair_compare_seq #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_results(input string nm, input logic e, input logic any,
                              input logic [1:0] mi, input logic [3:0] mc);
      chk({nm, " eq"},   32'(bus_i.eq),           32'(e));
      chk({nm, " any"},  32'(bus_i.any_match),    32'(any));
      chk({nm, " midx"}, 32'(bus_i.mismatch_idx), 32'(mi));
      chk({nm, " cnt"},  32'(bus_i.mismatch_cnt), 32'(mc));
   endtask

   // Start at edge 0, scramble operands after acceptance, expect done in cycle 5.
   task automatic run_cmp(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic e, input logic any, input logic [1:0] mi,
                          input logic [3:0] mc, input bit restart2, input bit abort_done);
      bus_i.a_in  = a;
      bus_i.b_in  = b;
      bus_i.start = 1'b1;
      tick();
      bus_i.start = 1'b0;
      bus_i.a_in  = ~a;
      bus_i.b_in  = a;
      chk({nm, " busy c1"}, 32'(bus_i.busy), 32'd1);
      chk({nm, " done c1"}, 32'(bus_i.done), 32'd0);
      for (int c = 2; c <= 4; c++) begin
         tick();
         bus_i.start = (restart2 && c == 2);
         chk($sformatf("%s done c%0d", nm, c), 32'(bus_i.done), 32'd0);
      end
      tick();
      bus_i.start = 1'b0;
      chk({nm, " done c5"}, 32'(bus_i.done), 32'd1);
      chk({nm, " busy c5"}, 32'(bus_i.busy), 32'd1);
      chk_results({nm, " c5"}, e, any, mi, mc);
      bus_i.abort = abort_done;
      tick();
      bus_i.abort = 1'b0;
      chk({nm, " done c6"}, 32'(bus_i.done), 32'd0);
      chk({nm, " busy c6"}, 32'(bus_i.busy), 32'd0);
      chk_results({nm, " hold"}, e, any, mi, mc);
      tick();
      chk({nm, " no 2nd done"}, 32'(bus_i.done), 32'd0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus_i.start = 1'b0;
      bus_i.abort = 1'b0;
      bus_i.a_in  = 8'h00;
      bus_i.b_in  = 8'h00;

      #2;
      chk("reset busy", 32'(bus_i.busy), 32'd0);
      chk("reset done", 32'(bus_i.done), 32'd0);
      chk_results("reset", 1'b0, 1'b0, 2'd0, 4'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      run_cmp("t1",   8'hA5, 8'hA5, 1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0);
      run_cmp("t2",   8'h00, 8'hFF, 1'b0, 1'b0, 2'd0, 4'd8, 1'b0, 1'b0);
      run_cmp("t3",   8'h3C, 8'h7C, 1'b0, 1'b1, 2'd3, 4'd1, 1'b0, 1'b1);
      run_cmp("t4",   8'h01, 8'h02, 1'b0, 1'b1, 2'd0, 4'd2, 1'b1, 1'b0);

      bus_i.a_in  = 8'h55;
      bus_i.b_in  = 8'h55;
      bus_i.start = 1'b1;
      bus_i.abort = 1'b1;
      tick();
      bus_i.start = 1'b0;
      bus_i.abort = 1'b0;
      chk("start+abort idle busy", 32'(bus_i.busy), 32'd0);
      chk_results("start+abort idle", 1'b0, 1'b1, 2'd0, 4'd2);

      bus_i.a_in  = 8'h12;
      bus_i.b_in  = 8'h34;
      bus_i.start = 1'b1;
      tick();
      bus_i.start = 1'b0;
      tick();
      bus_i.abort = 1'b1;
      tick();
      bus_i.abort = 1'b0;
      chk("t5 abort busy c3", 32'(bus_i.busy), 32'd0);
      for (int c = 3; c <= 6; c++) begin
         chk($sformatf("t5 abort done c%0d", c), 32'(bus_i.done), 32'd0);
         chk_results($sformatf("t5 abort c%0d", c), 1'b0, 1'b0, 2'd0, 4'd0);
         tick();
      end
      run_cmp("t5b",  8'hF0, 8'hF0, 1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0);

      bus_i.a_in  = 8'hC3;
      bus_i.b_in  = 8'h00;
      bus_i.start = 1'b1;
      tick();
      bus_i.start = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6 async busy", 32'(bus_i.busy), 32'd0);
      chk("t6 async done", 32'(bus_i.done), 32'd0);
      chk_results("t6 async", 1'b0, 1'b0, 2'd0, 4'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6 post-reset busy", 32'(bus_i.busy), 32'd0);
      run_cmp("t6b",  8'h0F, 8'h0E, 1'b0, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pair_compare_seq.md
Name: pair_compare_seq

Overview:
- Sequential controller that compares two WIDTH-bit operands two bits per clock, using one 2-bit pair-match cell.
- The cell's slice result is "at least one bit position in the slice is equal"; the cell also exposes per-bit equality.
- Accumulates equal / any-match / first-mismatch / mismatch-count results across all slices and reports them with a start/done handshake.
- Sits between a requesting datapath and the shared compare cell; it is the only sequencer of that cell.

Parameters:
- WIDTH, 8: operand width. Must be even and ≥ 2.
- NSLICE, WIDTH/2: number of 2-bit slices. Derived; do not override.
- IDXW, max(1, clog2(NSLICE)): slice-index width. Derived.
- CNTW, clog2(WIDTH+1): mismatch-count width. Derived.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request to compare a_in/b_in. Sampled only in IDLE.
- abort  in  1  cancel an in-progress comparison.
- a_in  in  WIDTH  operand A. Latched when start is accepted.
- b_in  in  WIDTH  operand B. Latched when start is accepted.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- eq  out  1  all WIDTH bits equal.
- any_match  out  1  OR of all slice-cell outputs.
- mismatch_idx  out  IDXW  lowest slice (LSB-first) containing a differing bit. 0 when eq=1.
- mismatch_cnt  out  CNTW  number of differing bit positions.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, eq, any_match, mismatch_idx, mismatch_cnt all 0. Latched operands 0. Outputs go to 0 immediately, independent of clk.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, start=1, abort=0:
  - latch a_in/b_in; slice idx=0
  - clear accumulators: eq_acc=1, any_acc=0, cnt=0, found=0, midx=0
  - clear visible result outputs to 0
  - next state RUN
- IDLE, start=1 and abort=1 in the same cycle: abort wins. Start is ignored, remain IDLE.
- RUN, each cycle, evaluating slice idx (bits 2*idx+1 : 2*idx):
  - eq_acc &= both bits equal
  - any_acc |= cell output
  - cnt += number of differing bits in the slice (0..2)
  - if found=0 and the slice has a difference: midx=idx, found=1
  - idx increments
  - after slice NSLICE-1, next state DONE
- DONE: one cycle. done=1, busy=1. eq/any_match/mismatch_idx/mismatch_cnt load from the final accumulators. Next state IDLE.
- Latency: start sampled at edge 0 → RUN for NSLICE cycles → done high in cycle NSLICE+1 (cycle 5 for WIDTH=8). Throughput: one compare per NSLICE+2 cycles.
- Result outputs hold after done until the next accepted start, which clears them.
- start while busy: ignored, not queued.
- abort in RUN: next state IDLE; busy=0 next cycle; no done pulse; result outputs stay 0.
- abort in DONE: ignored; the done pulse completes.
- cnt never overflows, since the maximum value is WIDTH, which fits in CNTW bits.
- Operand changes on a_in/b_in after acceptance have no effect.
- Reset mid-RUN: immediate return to reset values. A fresh start afterwards behaves normally.

Decomposition:
- Package pair_compare_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - SLICE_W=2
  - the derived-width helper functions
- One sub-module, pair_match_cell: combinational 2-bit slice.
  - inputs x1, x2, y1, y2
  - outputs: per-bit equal e1/e2, and a = e1|e2
  - the controller instantiates exactly one and muxes the current slice into it

Test Plan (WIDTH=8):
1. a=0xA5, b=0xA5, start at cycle 0 → done pulse in cycle 5; eq=1, any_match=1, mismatch_cnt=0, mismatch_idx=0.
2. a=0x00, b=0xFF → eq=0, any_match=0, mismatch_cnt=8, mismatch_idx=0.
3. a=0x3C, b=0x7C → eq=0, any_match=1, mismatch_cnt=1, mismatch_idx=3.
4. a=0x01, b=0x02 → eq=0, any_match=1, mismatch_cnt=2, mismatch_idx=0. Also: start pulsed again in cycle 2 is ignored (single done in cycle 5).
5. Start, then abort in cycle 2 → busy=0 in cycle 3, no done pulse, outputs 0. A new start (a=0xF0, b=0xF0) then gives eq=1 with correct latency.
6. rst_n low mid-RUN (cycle 3) → busy and all outputs 0 without waiting for a clock edge. After release, start with a=0x0F, b=0x0E → mismatch_cnt=1, mismatch_idx=0.
